// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Branch predictor: a gshare pattern history table (2-bit saturating
//   counters indexed by pc ^ global history), a partially tagged BTB and a
//   hardware sweep that initialises both tables after reset. Queried with the
//   fetch PC, trained with the resolved outcome plus the metadata that was
//   handed out at prediction time.
//
//   Build option: define BP_GSHARE_EN to hash the global history into the PHT
//   index. Without it the PHT is indexed by the PC alone (bimodal) and the
//   history register does not exist; the metadata layout is unchanged.
//
//   Ports
//     clk, rst          clock, asynchronous active-low reset
//     bp_oe, bp_pc      sample a fetch PC (bp_oe low holds the outputs)
//     bp_taken          predicted taken (counter taken-half and BTB hit)
//     bp_target         BTB target on hit, else bp_pc + 4
//     bp_meta           {pht idx, bp_taken, ctr}; returned later on fb_meta
//     fb_we             train strobe for a resolved control-transfer insn
//     fb_pc, fb_taken   resolved PC and direction
//     fb_target         resolved target
//     fb_meta           bp_meta captured for this insn at prediction
//     init_busy         table sweep in progress (predictions forced not-taken)
//     cnt_pred, cnt_hit trained predictions / correct direction predictions
module gshare_predictor #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 10,
    parameter int GHR_W = 8,
    parameter int TAG_W = 8,
    localparam int META_W = IDX_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bp_oe,
    input  logic [PC_W-1:0]   bp_pc,
    output logic              bp_taken,
    output logic [PC_W-1:0]   bp_target,
    output logic [META_W-1:0] bp_meta,
    input  logic              fb_we,
    input  logic [PC_W-1:0]   fb_pc,
    input  logic              fb_taken,
    input  logic [PC_W-1:0]   fb_target,
    input  logic [META_W-1:0] fb_meta,
    output logic              init_busy,
    output logic [31:0]       cnt_pred,
    output logic [31:0]       cnt_hit
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic { ST_INIT, ST_RUN } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                bp_taken_q, bp_taken_d;
    logic [PC_W-1:0]     bp_target_q, bp_target_d;
    logic [META_W-1:0]   bp_meta_q, bp_meta_d;
    logic [31:0]         cnt_pred_q, cnt_pred_d;
    logic [31:0]         cnt_hit_q, cnt_hit_d;
`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0]    ghr_q, ghr_d;
`endif

    logic [1:0]          pht_mem        [DEPTH];
    logic                btb_valid_mem  [DEPTH];
    logic [TAG_W-1:0]    btb_tag_mem    [DEPTH];
    logic [PC_W-1:0]     btb_target_mem [DEPTH];

    logic                run;
    logic                train;
    logic [IDX_W-1:0]    pc_idx;
    logic [IDX_W-1:0]    pred_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic                btb_hit;
    logic [1:0]          pred_ctr;
    logic [IDX_W-1:0]    fb_btb_idx;
    logic [IDX_W-1:0]    fb_pht_idx;
    logic [TAG_W-1:0]    fb_tag;
    logic [1:0]          new_ctr;
    logic                unused_bits;

    assign run        = (state_q == ST_RUN);
    assign train      = run && fb_we;
    assign pc_idx     = bp_pc[2 +: IDX_W];
    assign pc_tag     = bp_pc[2 + IDX_W +: TAG_W];
    assign fb_btb_idx = fb_pc[2 +: IDX_W];
    assign fb_tag     = fb_pc[2 + IDX_W +: TAG_W];
    assign fb_pht_idx = fb_meta[META_W-1:3];

`ifdef BP_GSHARE_EN
    // History occupies the low index bits; shorter histories are zero-extended.
    assign pred_idx = pc_idx ^ IDX_W'(ghr_q);
`else
    assign pred_idx = pc_idx;
`endif

    // Tables hold garbage until the sweep finishes, so reads are masked in INIT.
    assign btb_hit  = run && btb_valid_mem[pc_idx] && (btb_tag_mem[pc_idx] == pc_tag);
    assign pred_ctr = run ? pht_mem[pred_idx] : 2'b01;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        bp_taken_d  = bp_taken_q;
        bp_target_d = bp_target_q;
        bp_meta_d   = bp_meta_q;
        cnt_pred_d  = cnt_pred_q;
        cnt_hit_d   = cnt_hit_q;
        new_ctr     = fb_meta[1:0];
`ifdef BP_GSHARE_EN
        ghr_d       = ghr_q;
`endif

        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + IDX_W'(1);
            if (&ptr_q) state_d = ST_RUN;
        end

        if (bp_oe) begin
            bp_taken_d  = btb_hit && pred_ctr[1];
            bp_target_d = btb_hit ? btb_target_mem[pc_idx] : bp_pc + PC_W'(4);
            bp_meta_d   = {pred_idx, btb_hit && pred_ctr[1], pred_ctr};
        end

        if (train) begin
            // Counter update works from the value seen at prediction time.
            if (fb_taken) begin
                if (fb_meta[1:0] != 2'b11) new_ctr = fb_meta[1:0] + 2'b01;
            end else begin
                if (fb_meta[1:0] != 2'b00) new_ctr = fb_meta[1:0] - 2'b01;
            end
`ifdef BP_GSHARE_EN
            ghr_d = {ghr_q[GHR_W-2:0], fb_taken};
`endif
            cnt_pred_d = cnt_pred_q + 32'd1;
            if (fb_meta[2] == fb_taken) cnt_hit_d = cnt_hit_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            bp_taken_q  <= 1'b0;
            bp_target_q <= '0;
            bp_meta_q   <= '0;
            cnt_pred_q  <= '0;
            cnt_hit_q   <= '0;
`ifdef BP_GSHARE_EN
            ghr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            bp_taken_q  <= bp_taken_d;
            bp_target_q <= bp_target_d;
            bp_meta_q   <= bp_meta_d;
            cnt_pred_q  <= cnt_pred_d;
            cnt_hit_q   <= cnt_hit_d;
`ifdef BP_GSHARE_EN
            ghr_q       <= ghr_d;
`endif
        end
    end

    // NOTE: the tables are kept out of the reset so they map onto RAM; the
    // INIT sweep gives them defined contents instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            pht_mem[ptr_q]       <= 2'b01;
            btb_valid_mem[ptr_q] <= 1'b0;
        end else if (train) begin
            pht_mem[fb_pht_idx] <= new_ctr;
            if (fb_taken) begin
                btb_valid_mem[fb_btb_idx]  <= 1'b1;
                btb_tag_mem[fb_btb_idx]    <= fb_tag;
                btb_target_mem[fb_btb_idx] <= {fb_target[PC_W-1:1], 1'b0};
            end
        end
    end

    assign bp_taken  = bp_taken_q;
    assign bp_target = bp_target_q;
    assign bp_meta   = bp_meta_q;
    assign init_busy = (state_q == ST_INIT);
    assign cnt_pred  = cnt_pred_q;
    assign cnt_hit   = cnt_hit_q;

    // PC bits outside the index/tag fields and the target LSB are don't-care.
    assign unused_bits = ^{fb_pc[1:0], fb_pc[PC_W-1:2+IDX_W+TAG_W], fb_target[0]};

endmodule
